// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants, used by the BTB and by branch_unit.
package bp_pkg;

  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_PC_WIDTH   = 32;
  localparam int TAG_BITS       = DEF_PC_WIDTH - DEF_INDEX_BITS - 2;

  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS-1:0]     tag;
    logic [DEF_PC_WIDTH-1:0] target;
    logic                    pred;
  } bp_entry_t;

  localparam logic [1:0] HP_MISS   = 2'b00;
  localparam logic [1:0] HP_HIT_NT = 2'b10;
  localparam logic [1:0] HP_HIT_T  = 2'b11;

endpackage

// File: rtl/branch_pred_table_if.sv
// Fetch-side lookup, IF/ID copy and branch_unit update signals of the BTB.
interface branch_pred_table_if
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
);
  logic [PC_WIDTH-1:0] pc_if;
  logic                stall;
  logic                flush;
  logic [1:0]          Hp;
  logic [PC_WIDTH-1:0] pred_target;
  logic [1:0]          Hpd;
  logic [PC_WIDTH-1:0] pc_id;
  logic                Wrt;
  logic                Wrp;
  logic                upd_taken;
  logic [PC_WIDTH-1:0] upd_target;

  modport master (
    output pc_if, stall, flush, Wrt, Wrp, upd_taken, upd_target,
    input  Hp, pred_target, Hpd, pc_id
  );

  modport slave (
    input  pc_if, stall, flush, Wrt, Wrp, upd_taken, upd_target,
    output Hp, pred_target, Hpd, pc_id
  );
endinterface

// File: rtl/bp_table_mem.sv
// BTB entry storage: async-reset registers, one combinational read port and
// one indexed write port with separate tag/target and prediction enables.
module bp_table_mem
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output bp_entry_t             rd_entry,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_tgt_en,
  input  logic                  wr_pred_en,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DEF_PC_WIDTH-1:0] wr_target,
  input  logic                  wr_pred
);
  localparam int DEPTH = 1 << INDEX_BITS;

  bp_entry_t entry_arr [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      bp_entry_t entry_reg;
      logic      sel;

      assign sel = (wr_idx == INDEX_BITS'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (sel) begin
          // Field enables are independent so a prediction-only write leaves valid alone.
          if (wr_tgt_en) begin
            entry_reg.valid  <= 1'b1;
            entry_reg.tag    <= wr_tag;
            entry_reg.target <= wr_target;
          end
          if (wr_pred_en) begin
            entry_reg.pred <= wr_pred;
          end
        end
      end

      assign entry_arr[gi] = entry_reg;
    end
  endgenerate

  assign rd_entry = entry_arr[rd_idx];

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped BTB with 1-bit prediction: IF lookup, IF/ID result register,
// and table updates addressed by the instruction currently in ID.
module branch_pred_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_pred_table_if.slave  bus
);
  localparam int TAG_W = PC_WIDTH - INDEX_BITS - 2;

  logic [INDEX_BITS-1:0] idx_if;
  logic [INDEX_BITS-1:0] idx_id;
  logic [TAG_W-1:0]      tag_if;
  logic [TAG_W-1:0]      tag_id;
  bp_entry_t             rd_entry;
  logic                  hit;
  logic [1:0]            hp_id_reg;
  logic [PC_WIDTH-1:0]   pc_id_reg;

  assign idx_if = bus.pc_if[INDEX_BITS+1:2];
  assign tag_if = bus.pc_if[PC_WIDTH-1:INDEX_BITS+2];
  assign idx_id = pc_id_reg[INDEX_BITS+1:2];
  assign tag_id = pc_id_reg[PC_WIDTH-1:INDEX_BITS+2];

  bp_table_mem #(
    .INDEX_BITS (INDEX_BITS)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (idx_if),
    .rd_entry   (rd_entry),
    .wr_idx     (idx_id),
    .wr_tgt_en  (bus.Wrt),
    .wr_pred_en (bus.Wrp),
    .wr_tag     (tag_id),
    .wr_target  (bus.upd_target),
    .wr_pred    (bus.upd_taken)
  );

  // No write-to-read bypass: a lookup in the write cycle sees the old entry.
  assign hit             = rd_entry.valid && (rd_entry.tag == tag_if);
  assign bus.Hp          = !hit ? HP_MISS : (rd_entry.pred ? HP_HIT_T : HP_HIT_NT);
  assign bus.pred_target = hit ? rd_entry.target : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_id_reg <= HP_MISS;
      pc_id_reg <= '0;
    end else if (bus.flush) begin
      hp_id_reg <= HP_MISS;
      pc_id_reg <= '0;
    end else if (!bus.stall) begin
      hp_id_reg <= bus.Hp;
      pc_id_reg <= bus.pc_if;
    end
  end

  assign bus.Hpd   = hp_id_reg;
  assign bus.pc_id = pc_id_reg;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench for branch_pred_table: reset, install, flip, alias, pipeline control.
module tb_branch_pred_table;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  branch_pred_table_if #(.PC_WIDTH(32)) bus ();

  branch_pred_table #(.INDEX_BITS(4), .PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    bus.Wrt = 1'b0;
    bus.Wrp = 1'b0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pc_if = 32'h40;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_upd();
    #23;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL reset_hp: got %b want 00", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h0) $display("FAIL reset_tgt: got %h want 0", bus.pred_target); else pass_cnt++;
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL reset_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    total_cnt++; if (bus.pc_id !== 32'h0) $display("FAIL reset_pcid: got %h want 0", bus.pc_id); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL first_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    total_cnt++; if (bus.pc_id !== 32'h40) $display("FAIL first_pcid: got %h want 40", bus.pc_id); else pass_cnt++;
    $display("reset: Hp=%b Hpd=%b pc_id=%h", bus.Hp, bus.Hpd, bus.pc_id);
  endtask

  task automatic test_install();
    bus.Wrt = 1'b1; bus.Wrp = 1'b1; bus.upd_taken = 1'b1; bus.upd_target = 32'h80;
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL install_same_cycle_hp: got %b want 00", bus.Hp); else pass_cnt++;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b11) $display("FAIL install_hp: got %b want 11", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h80) $display("FAIL install_tgt: got %h want 80", bus.pred_target); else pass_cnt++;
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL install_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    $display("install 0x40: Hp=%b tgt=%h", bus.Hp, bus.pred_target);
  endtask

  task automatic test_flip();
    bus.Wrp = 1'b1; bus.upd_taken = 1'b0;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b10) $display("FAIL flip_hp: got %b want 10", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h80) $display("FAIL flip_tgt: got %h want 80", bus.pred_target); else pass_cnt++;
    bus.Wrt = 1'b1; bus.upd_target = 32'hC0;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b10) $display("FAIL wrt_only_hp: got %b want 10", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'hC0) $display("FAIL wrt_only_tgt: got %h want c0", bus.pred_target); else pass_cnt++;
    total_cnt++; if (bus.Hpd !== 2'b10) $display("FAIL flip_hpd: got %b want 10", bus.Hpd); else pass_cnt++;
    $display("flip 0x40: Hp=%b tgt=%h", bus.Hp, bus.pred_target);
  endtask

  task automatic test_wrp_invalid();
    bus.pc_if = 32'h44;
    step();
    bus.Wrp = 1'b1; bus.upd_taken = 1'b1;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL wrp_invalid_hp: got %b want 00", bus.Hp); else pass_cnt++;
    bus.Wrt = 1'b1; bus.upd_target = 32'h100;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b11) $display("FAIL wrt_after_wrp_hp: got %b want 11", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h100) $display("FAIL wrt_after_wrp_tgt: got %h want 100", bus.pred_target); else pass_cnt++;
    $display("wrp on invalid 0x44 then wrt: Hp=%b tgt=%h", bus.Hp, bus.pred_target);
  endtask

  task automatic test_alias();
    bus.pc_if = 32'h80;
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL alias_miss_hp: got %b want 00", bus.Hp); else pass_cnt++;
    step();
    bus.Wrt = 1'b1; bus.Wrp = 1'b1; bus.upd_taken = 1'b0; bus.upd_target = 32'h200;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b10) $display("FAIL alias_install_hp: got %b want 10", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h200) $display("FAIL alias_install_tgt: got %h want 200", bus.pred_target); else pass_cnt++;
    bus.pc_if = 32'h40;
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL alias_evict_hp: got %b want 00", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h0) $display("FAIL alias_evict_tgt: got %h want 0", bus.pred_target); else pass_cnt++;
    bus.pc_if = 32'h83;
    #1;
    total_cnt++; if (bus.Hp !== 2'b10) $display("FAIL low_bits_ignored_hp: got %b want 10", bus.Hp); else pass_cnt++;
    $display("alias 0x80 over 0x40: Hp(0x83)=%b", bus.Hp);
  endtask

  task automatic test_pipeline();
    logic [31:0] pcs [3];
    pcs[0] = 32'h80; pcs[1] = 32'h40; pcs[2] = 32'h48;
    bus.pc_if = 32'h44;
    step();
    total_cnt++; if (bus.Hpd !== 2'b11) $display("FAIL pipe_load_hpd: got %b want 11", bus.Hpd); else pass_cnt++;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_if = pcs[i];
      step();
      total_cnt++; if (bus.Hpd !== 2'b11) $display("FAIL stall_hpd_%0d: got %b want 11", i, bus.Hpd); else pass_cnt++;
      total_cnt++; if (bus.pc_id !== 32'h44) $display("FAIL stall_pcid_%0d: got %h want 44", i, bus.pc_id); else pass_cnt++;
      $display("stall cycle %0d: pc_if=%h Hpd=%b pc_id=%h", i, bus.pc_if, bus.Hpd, bus.pc_id);
    end
    bus.flush = 1'b1;
    step();
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL flush_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    total_cnt++; if (bus.pc_id !== 32'h0) $display("FAIL flush_pcid: got %h want 0", bus.pc_id); else pass_cnt++;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    $display("stall+flush: Hpd=%b pc_id=%h", bus.Hpd, bus.pc_id);
  endtask

  task automatic test_back_to_back();
    bus.pc_if = 32'h40;
    step();
    bus.Wrt = 1'b1; bus.Wrp = 1'b1; bus.upd_taken = 1'b1; bus.upd_target = 32'h300;
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL rw_same_cycle_hp: got %b want 00", bus.Hp); else pass_cnt++;
    step();
    clear_upd();
    #1;
    total_cnt++; if (bus.Hp !== 2'b11) $display("FAIL rw_next_cycle_hp: got %b want 11", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h300) $display("FAIL rw_next_cycle_tgt: got %h want 300", bus.pred_target); else pass_cnt++;
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL rw_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    $display("same-cycle write/read 0x40: next Hp=%b tgt=%h", bus.Hp, bus.pred_target);
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [3];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h0;
    bus.pc_if = 32'h44;
    step();
    total_cnt++; if (bus.Hpd !== 2'b11) $display("FAIL pre_rst_hpd: got %b want 11", bus.Hpd); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL mid_rst_hp: got %b want 00", bus.Hp); else pass_cnt++;
    total_cnt++; if (bus.pred_target !== 32'h0) $display("FAIL mid_rst_tgt: got %h want 0", bus.pred_target); else pass_cnt++;
    total_cnt++; if (bus.Hpd !== 2'b00) $display("FAIL mid_rst_hpd: got %b want 00", bus.Hpd); else pass_cnt++;
    total_cnt++; if (bus.pc_id !== 32'h0) $display("FAIL mid_rst_pcid: got %h want 0", bus.pc_id); else pass_cnt++;
    bus.Wrt = 1'b1; bus.Wrp = 1'b1; bus.upd_taken = 1'b1; bus.upd_target = 32'h500;
    step();
    step();
    @(negedge clk);
    clear_upd();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_if = pcs[i];
      #1;
      total_cnt++; if (bus.Hp !== 2'b00) $display("FAIL post_rst_hp_%h: got %b want 00", pcs[i], bus.Hp); else pass_cnt++;
      $display("after reset lookup %h: Hp=%b", pcs[i], bus.Hp);
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_install();
    test_flip();
    test_wrp_invalid();
    test_alias();
    test_pipeline();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
